// File: rtl/jpeg_rle_block_decoder.sv
// Expands one 8x8 block of Huffman-decoded run/size/amplitude symbols into
// 64 zig-zag ordered signed coefficients, restoring DC from its differential.
module jpeg_rle_block_decoder #(
  parameter int COEF_W = 12,
  parameter int PRED_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dc_clear,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [3:0]        sym_run,
  input  logic [3:0]        sym_size,
  input  logic [COEF_W-1:0] sym_amp,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [5:0]        coef_idx,
  output logic              coef_last,
  output logic              blk_err
);

  // Handshakes: a beat moves on a rising edge where valid & ready are both
  // high; a source holds its payload stable until that edge.
  typedef enum logic [2:0] {S_DC, S_AC_SYM, S_ZEROS, S_VALUE, S_FILL} state_t;

  state_t              state, state_n;
  logic [5:0]          nidx, nidx_n;
  logic [3:0]          zcnt, zcnt_n;
  logic [COEF_W-1:0]   hold, hold_n;
  logic                has_val, has_val_n;
  logic                err_flag, err_n;
  logic [PRED_W-1:0]   pred, pred_n, pred_base, pred_sum;
  logic                armed;
  logic                adv, accept;
  logic                emit, e_last, e_err;
  logic [COEF_W-1:0]   e_data, amp_ext;
  logic [6:0]          rem, need;
  logic                is_eob, is_zrl;

  function automatic logic [COEF_W-1:0] extend(input logic [3:0] size,
                                               input logic [COEF_W-1:0] amp);
    int s;
    logic [COEF_W:0] mask, m_amp;
    s     = (int'(size) > COEF_W) ? COEF_W : int'(size);
    mask  = ((COEF_W+1)'(1) << s) - (COEF_W+1)'(1);
    m_amp = {1'b0, amp} & mask;
    if (s == 0) return '0;
    if (m_amp[s-1]) return m_amp[COEF_W-1:0];
    return COEF_W'(m_amp - mask);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_DC;
    else        state <= state_n;
  end

  // Next-state and datapath control
  always_comb begin
    state_n   = state;
    nidx_n    = nidx;
    zcnt_n    = zcnt;
    hold_n    = hold;
    has_val_n = has_val;
    err_n     = err_flag;
    pred_base = dc_clear ? '0 : pred;
    pred_n    = pred_base;
    emit      = 1'b0;
    e_data    = '0;
    amp_ext   = extend(sym_size, sym_amp);
    pred_sum  = pred_base + PRED_W'($signed(amp_ext));
    rem       = 7'd64 - {1'b0, nidx};
    is_eob    = (sym_run == 4'd0) && (sym_size == 4'd0);
    is_zrl    = (sym_run == 4'd15) && (sym_size == 4'd0);
    need      = is_zrl ? 7'd16 : ({3'b000, sym_run} + 7'd1);
    case (state)
      S_DC: if (accept) begin
        pred_n = pred_sum;
        if (adv) begin
          emit    = 1'b1;
          e_data  = COEF_W'($signed(pred_sum));
          state_n = S_AC_SYM;
        end else begin
          hold_n    = COEF_W'($signed(pred_sum));
          has_val_n = 1'b1;
          state_n   = S_VALUE;
        end
      end
      // The first beat of every AC symbol goes out on the accepting edge.
      S_AC_SYM: if (accept) begin
        emit = 1'b1;
        if (is_eob) begin
          state_n = S_FILL;
        end else if (need > rem) begin
          err_n     = 1'b1;
          has_val_n = 1'b0;
          state_n   = S_FILL;
        end else if (is_zrl) begin
          zcnt_n    = 4'd15;
          has_val_n = 1'b0;
          state_n   = S_ZEROS;
        end else if (sym_run == 4'd0) begin
          e_data = amp_ext;
        end else begin
          zcnt_n    = sym_run - 4'd1;
          hold_n    = amp_ext;
          has_val_n = 1'b1;
          state_n   = (sym_run == 4'd1) ? S_VALUE : S_ZEROS;
        end
      end
      S_ZEROS: if (adv) begin
        emit   = 1'b1;
        zcnt_n = zcnt - 4'd1;
        if (zcnt == 4'd1) state_n = has_val ? S_VALUE : S_AC_SYM;
      end
      S_VALUE: if (adv) begin
        emit      = 1'b1;
        e_data    = hold;
        has_val_n = 1'b0;
        state_n   = S_AC_SYM;
      end
      S_FILL: if (adv) emit = 1'b1;
      default: state_n = S_DC;
    endcase
    e_err  = err_n;
    e_last = (nidx == 6'd63);
    if (emit) begin
      nidx_n = nidx + 6'd1;
      if (e_last) begin
        state_n   = S_DC;
        err_n     = 1'b0;
        has_val_n = 1'b0;
      end
    end
  end

  // Outputs derived from state
  always_comb begin
    adv       = !coef_valid || coef_ready;
    sym_ready = armed && ((state == S_DC) || ((state == S_AC_SYM) && adv));
    accept    = sym_valid && sym_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nidx       <= '0;
      zcnt       <= '0;
      hold       <= '0;
      has_val    <= 1'b0;
      err_flag   <= 1'b0;
      pred       <= '0;
      armed      <= 1'b0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      blk_err    <= 1'b0;
    end else begin
      nidx     <= nidx_n;
      zcnt     <= zcnt_n;
      hold     <= hold_n;
      has_val  <= has_val_n;
      err_flag <= err_n;
      pred     <= pred_n;
      armed    <= 1'b1;
      blk_err  <= emit && e_last && e_err;
      if (emit) begin
        coef_valid <= 1'b1;
        coef_data  <= e_data;
        coef_idx   <= nidx;
        coef_last  <= e_last;
      end else if (coef_ready) begin
        coef_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_rle_block_decoder.sv
// Directed bench for jpeg_rle_block_decoder: hand-computed blocks are queued
// as expected coefficients and compared against captured output beats.
module tb_jpeg_rle_block_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dc_clear;
  logic        sym_valid;
  logic        sym_ready;
  logic [3:0]  sym_run;
  logic [3:0]  sym_size;
  logic [11:0] sym_amp;
  logic        coef_valid;
  logic        coef_ready;
  logic [11:0] coef_data;
  logic [5:0]  coef_idx;
  logic        coef_last;
  logic        blk_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_data[$];
  logic [5:0]  got_idx[$];
  logic        got_last[$];
  logic [11:0] exp_blk[64];

  int          err_cnt = 0;
  logic [5:0]  err_idx = '0;
  int          stab_err = 0;
  int          stall_cnt = 0;
  bit          rnd_ready = 0;

  logic        prev_stall = 1'b0;
  logic [11:0] prev_data;
  logic [5:0]  prev_idx;
  logic        prev_last;

  jpeg_rle_block_decoder #(.COEF_W(12), .PRED_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .dc_clear(dc_clear),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_idx(coef_idx),
    .coef_last(coef_last), .blk_err(blk_err)
  );

  // Clock and reset-independent ready driver
  always #5 clk = ~clk;

  initial begin
    coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      coef_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: inputs only change just after posedge, so negedge reflects the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!coef_valid || coef_data != prev_data ||
                         coef_idx != prev_idx || coef_last != prev_last))
        stab_err++;
      if (blk_err) begin
        err_cnt++;
        err_idx = coef_idx;
      end
      if (coef_valid && coef_ready) begin
        got_data.push_back(coef_data);
        got_idx.push_back(coef_idx);
        got_last.push_back(coef_last);
      end
      prev_stall = coef_valid && !coef_ready;
      if (prev_stall) stall_cnt++;
      prev_data = coef_data;
      prev_idx  = coef_idx;
      prev_last = coef_last;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: present one symbol and hold it until accepted (bounded)
  task automatic send_sym(input logic [3:0] run, input logic [3:0] size,
                          input logic [11:0] amp, input logic clr);
    bit ok = 0;
    sym_valid = 1'b1;
    sym_run   = run;
    sym_size  = size;
    sym_amp   = amp;
    dc_clear  = clr;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = sym_ready;
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    dc_clear  = 1'b0;
    if (!ok) check("sym_accept_timeout", 0, 1);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = '0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 3000 && got_data.size() < n; c++) @(negedge clk);
    if (got_data.size() < n) check("beat_timeout", got_data.size(), n);
  endtask

  task automatic check_block(input string name);
    for (int i = 0; i < 64; i++) exp_q.push_back(exp_blk[i]);
    wait_beats(64);
    for (int i = 0; i < 64 && got_data.size() > 0; i++) begin
      check({name, "_data"}, got_data.pop_front(), exp_q.pop_front());
      check({name, "_idx"},  got_idx.pop_front(), i);
      check({name, "_last"}, got_last.pop_front(), (i == 63));
    end
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test2_syms();
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    send_sym(4'd2, 4'd1, 12'h000, 1'b0);
    send_sym(4'd0, 4'd4, 12'h00A, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dc_clear = 1'b0; sym_valid = 1'b0;
    sym_run = '0; sym_size = '0; sym_amp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sym_ready", sym_ready, 0);
    check("rst_coef_valid", coef_valid, 0);
    check("rst_coef_data", coef_data, 0);
    check("rst_coef_idx", coef_idx, 0);
    check("rst_coef_last", coef_last, 0);
    check("rst_blk_err", blk_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_sym_ready", sym_ready, 1);

    // Test 1: DC +5 then EOB; second block DC -2 gives 3
    send_sym(4'd0, 4'd3, 12'h005, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd5;
    check_block("t1a");
    send_sym(4'd0, 4'd2, 12'h001, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd3;
    check_block("t1b");

    // Test 2: DC diff 0 (pred 3), run2 -> -1 at idx3, 10 at idx4
    test2_syms();
    clear_exp(); exp_blk[0] = 12'd3; exp_blk[3] = 12'hFFF; exp_blk[4] = 12'd10;
    check_block("t2");

    // Test 3: DC -1 (pred 2), ZRL x3, run14 value 1 lands at idx63, no EOB
    send_sym(4'd0, 4'd1, 12'h000, 1'b0);
    for (int k = 0; k < 3; k++) send_sym(4'd15, 4'd0, 12'h000, 1'b0);
    send_sym(4'd14, 4'd1, 12'h001, 1'b0);
    clear_exp(); exp_blk[0] = 12'd2; exp_blk[63] = 12'd1;
    check_block("t3");
    check("t3_no_blk_err", err_cnt, 0);

    // Test 4: DC +1 (pred 3), ZRL x4 overflows; next symbol is DC +3 (pred 6)
    send_sym(4'd0, 4'd1, 12'h001, 1'b0);
    for (int k = 0; k < 4; k++) send_sym(4'd15, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd3;
    check_block("t4");
    check("t4_blk_err_cnt", err_cnt, 1);
    check("t4_blk_err_idx", err_idx, 63);
    send_sym(4'd0, 4'd2, 12'h003, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd6;
    check_block("t4_next_dc");

    // Test 5: test 2 pattern under random backpressure (pred stays 6)
    rnd_ready = 1;
    test2_syms();
    clear_exp(); exp_blk[0] = 12'd6; exp_blk[3] = 12'hFFF; exp_blk[4] = 12'd10;
    check_block("t5");
    rnd_ready = 0;
    check("t5_stall_stable", stab_err, 0);
    check("t5_stalls_seen", stall_cnt > 0, 1);

    // Test 6: lone dc_clear then DC +7; dc_clear with DC +1 gives 1
    @(posedge clk); #1;
    dc_clear = 1'b1;
    @(posedge clk); #1;
    dc_clear = 1'b0;
    send_sym(4'd0, 4'd3, 12'h007, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd7;
    check_block("t6_clear");
    send_sym(4'd0, 4'd1, 12'h001, 1'b1);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd1;
    check_block("t6_clear_with_dc");

    // Reset in mid block around idx 20
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    wait_beats(21);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_coef_valid", coef_valid, 0);
    check("t6_rst_coef_idx", coef_idx, 0);
    check("t6_rst_coef_data", coef_data, 0);
    check("t6_rst_coef_last", coef_last, 0);
    check("t6_rst_sym_ready", sym_ready, 0);
    got_data.delete(); got_idx.delete(); got_last.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_sym(4'd0, 4'd3, 12'h004, 1'b0);
    send_sym(4'd0, 4'd0, 12'h000, 1'b0);
    clear_exp(); exp_blk[0] = 12'd4;
    check_block("t6_after_rst");
    check("final_blk_err_cnt", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
